sst_reg_seq: RTL and testbench

SST_REG_SEQ -- requirements
Module: sst_reg_seq

---
 rtl/sst_reg_seq_pkg.sv | 20 ++
 rtl/sst_reg_seq.sv | 111 +++++++++++
 tb/tb_sst_reg_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sst_reg_seq_pkg.sv
// Shared mapper save-state definitions: default register map constants and
// the save/restore sequencer state encoding.
package sst_reg_seq_pkg;

  localparam int DEF_REG_CNT = 10;
  localparam int DEF_ID_ADDR = 127;

  typedef enum logic [3:0] {
    IDLE,
    RD_SET,
    RD_CAP,
    RD_OUT,
    WR_IN,
    WR_HOLD,
    ID_SET,
    ID_CHK,
    DONE
  } sst_state_e;

endpackage

// File: rtl/sst_reg_seq.sv
// Save-state sequencer: streams mapper registers plus the mapper ID byte out
// on save, and writes them back (checking the ID byte) on restore.
module sst_reg_seq
  import sst_reg_seq_pkg::*;
#(
  parameter int REG_CNT = DEF_REG_CNT,
  parameter int ID_ADDR = DEF_ID_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dir,
  input  logic       abort,
  input  logic       m2_fall,
  output logic       busy,
  output logic       done,
  output logic       id_err,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [7:0] sav_data,
  output logic       sav_valid,
  input  logic       sav_ready,
  input  logic [7:0] rs_data,
  input  logic       rs_valid,
  output logic       rs_ready
);

  localparam logic [7:0] LAST_IDX = 8'(REG_CNT);
  localparam logic [7:0] ID_A     = 8'(ID_ADDR);

  sst_state_e state;
  logic [7:0] idx;

  // idx == REG_CNT is the slot of the ID byte in both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 8'd0;
      id_err   <= 1'b0;
      sst_dato <= 8'd0;
      sav_data <= 8'd0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= 8'd0;
            id_err <= 1'b0;
            state  <= dir ? WR_IN : RD_SET;
          end
        end
        RD_SET: state <= RD_CAP;
        RD_CAP: begin
          sav_data <= sst_di;
          state    <= RD_OUT;
        end
        RD_OUT: begin
          if (sav_ready) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 8'd1;
              state <= RD_SET;
            end
          end
        end
        WR_IN: begin
          if (rs_valid) begin
            sst_dato <= rs_data;
            state    <= (idx == LAST_IDX) ? ID_SET : WR_HOLD;
          end
        end
        WR_HOLD: begin
          if (m2_fall) begin
            idx   <= idx + 8'd1;
            state <= WR_IN;
          end
        end
        ID_SET: state <= ID_CHK;
        ID_CHK: begin
          if (sst_di != sst_dato) id_err <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are a pure decode of the state/idx registers, so they follow
  // the asynchronous reset immediately.
  always_comb begin
    busy       = (state != IDLE);
    sst_act    = (state != IDLE);
    done       = (state == DONE);
    sst_we_reg = (state == WR_HOLD);
    sav_valid  = (state == RD_OUT);
    rs_ready   = (state == WR_IN);
    case (state)
      RD_SET, RD_CAP, RD_OUT: sst_addr = (idx == LAST_IDX) ? ID_A : idx;
      WR_IN, WR_HOLD:         sst_addr = idx;
      ID_SET, ID_CHK:         sst_addr = ID_A;
      default:                sst_addr = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_sst_reg_seq.sv
// Directed bench for sst_reg_seq: table of save/restore/abort commands against
// a small mapper register model, plus hand-written reset sequences.
module tb_sst_reg_seq;
  import sst_reg_seq_pkg::*;

  localparam int REG_CNT = 10;
  localparam int ID_ADDR = 127;
  localparam int MAX_CYC = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic       abort = 1'b0;
  logic       m2_fall = 1'b0;
  logic       busy, done, id_err, sst_act, sst_we_reg, sav_valid, rs_ready;
  logic [7:0] sst_addr, sst_dato, sav_data;
  logic [7:0] sst_di;
  logic       sav_ready = 1'b0;
  logic [7:0] rs_data = 8'd0;
  logic       rs_valid = 1'b0;

  logic [7:0] map_regs [REG_CNT];
  logic [7:0] map_id = 8'h50;
  logic       load_req = 1'b0;

  typedef struct {
    logic       dir;
    logic [7:0] id_byte;
    int         ready_mode;
    int         abort_idx;
    logic       exp_id_err;
    string      name;
  } vec_t;

  vec_t       vecs [6];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt, windows, stable_viol;
  logic       timed_out;
  logic [7:0] bytes [$];

  sst_reg_seq #(.REG_CNT(REG_CNT), .ID_ADDR(ID_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .abort(abort),
    .m2_fall(m2_fall), .busy(busy), .done(done), .id_err(id_err),
    .sst_act(sst_act), .sst_addr(sst_addr), .sst_we_reg(sst_we_reg),
    .sst_dato(sst_dato), .sst_di(sst_di), .sav_data(sav_data),
    .sav_valid(sav_valid), .sav_ready(sav_ready), .rs_data(rs_data),
    .rs_valid(rs_valid), .rs_ready(rs_ready)
  );

  always #5 clk = ~clk;

  // Mapper model: combinational readback, write on the m2 falling edge.
  always_comb begin
    sst_di = 8'd0;
    if (int'(sst_addr) < REG_CNT) sst_di = map_regs[int'(sst_addr)];
    else if (int'(sst_addr) == ID_ADDR) sst_di = map_id;
  end

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < REG_CNT; k++) map_regs[k] <= 8'(k);
    end else if (sst_we_reg && m2_fall && int'(sst_addr) < REG_CNT) begin
      map_regs[int'(sst_addr)] <= sst_dato;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_flags"},
                32'({busy, done, id_err, sst_act, sst_we_reg, sav_valid, rs_ready}), 32'd0);
    checkOutput({name, "_sst_addr"}, 32'(sst_addr), 32'd0);
    checkOutput({name, "_sst_dato"}, 32'(sst_dato), 32'd0);
    checkOutput({name, "_sav_data"}, 32'(sav_data), 32'd0);
  endtask

  task automatic preload();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int         ptr;
    logic       prev_we, prev_hold, saw_done;
    logic [7:0] held;
    bytes.delete();
    done_cnt = 0; windows = 0; stable_viol = 0; timed_out = 1'b1;
    ptr = 0; prev_we = 1'b0; prev_hold = 1'b0; held = 8'd0; saw_done = 1'b0;
    preload();
    dir   = v.dir;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({v.name, "_start_clears_id_err"}, 32'(id_err), 32'd0);
    checkOutput({v.name, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
      sav_ready = (v.ready_mode == 1) ? 1'b1 : (cyc % 3 == 2);
      rs_valid  = (ptr <= REG_CNT);
      rs_data   = (ptr < REG_CNT) ? 8'h11 + 8'(ptr) : v.id_byte;
      m2_fall   = (cyc % 5 == 4);
      if (v.abort_idx >= 0 && sst_we_reg && int'(sst_addr) == v.abort_idx) begin
        m2_fall = 1'b0;
        abort   = 1'b1;
      end
      if (prev_hold && sav_data !== held) stable_viol++;
      prev_hold = sav_valid && !sav_ready;
      held      = sav_data;
      if (sav_valid && sav_ready) bytes.push_back(sav_data);
      if (rs_valid && rs_ready) ptr++;
      if (sst_we_reg && !prev_we) windows++;
      prev_we = sst_we_reg;
      if (done) begin
        done_cnt++;
        saw_done = 1'b1;
      end
      @(negedge clk);
      if (abort) begin
        abort = 1'b0;
        checkOutput({v.name, "_abort_idle"}, 32'(busy), 32'd0);
        checkOutput({v.name, "_abort_we"}, 32'(sst_we_reg), 32'd0);
        checkOutput({v.name, "_abort_handshakes"}, 32'({sav_valid, rs_ready}), 32'd0);
        timed_out = 1'b0;
        break;
      end
      if (saw_done) begin
        timed_out = 1'b0;
        break;
      end
    end
    sav_ready = 1'b0;
    rs_valid  = 1'b0;
    m2_fall   = 1'b0;
    repeat (3) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic checkVector(input vec_t v);
    int lim;
    checkOutput({v.name, "_timeout"}, 32'(timed_out), 32'd0);
    checkOutput({v.name, "_done_pulses"}, 32'(done_cnt), (v.abort_idx >= 0) ? 32'd0 : 32'd1);
    checkOutput({v.name, "_idle_after"}, 32'(busy), 32'd0);
    if (!v.dir) begin
      checkOutput({v.name, "_byte_count"}, 32'(bytes.size()), 32'(REG_CNT + 1));
      for (int k = 0; k < bytes.size() && k <= REG_CNT; k++)
        checkOutput($sformatf("%s_byte%0d", v.name, k), 32'(bytes[k]),
                    (k < REG_CNT) ? 32'(k) : 32'h50);
      checkOutput({v.name, "_sav_data_stable"}, 32'(stable_viol), 32'd0);
    end else begin
      lim = (v.abort_idx >= 0) ? v.abort_idx : REG_CNT;
      checkOutput({v.name, "_id_err"}, 32'(id_err), 32'(v.exp_id_err));
      checkOutput({v.name, "_we_windows"}, 32'(windows),
                  (v.abort_idx >= 0) ? 32'(v.abort_idx + 1) : 32'(REG_CNT));
      for (int k = 0; k < REG_CNT; k++)
        checkOutput($sformatf("%s_reg%0d", v.name, k), 32'(map_regs[k]),
                    (k < lim) ? 32'(8'h11 + 8'(k)) : 32'(k));
    end
  endtask

  initial begin
    vecs[0] = '{dir: 1'b0, id_byte: 8'h50, ready_mode: 1, abort_idx: -1, exp_id_err: 1'b0, name: "save_rdy"};
    vecs[1] = '{dir: 1'b0, id_byte: 8'h50, ready_mode: 3, abort_idx: -1, exp_id_err: 1'b0, name: "save_bp"};
    vecs[2] = '{dir: 1'b1, id_byte: 8'h50, ready_mode: 1, abort_idx: -1, exp_id_err: 1'b0, name: "rest_ok"};
    vecs[3] = '{dir: 1'b1, id_byte: 8'h51, ready_mode: 1, abort_idx: -1, exp_id_err: 1'b1, name: "rest_bad_id"};
    vecs[4] = '{dir: 1'b1, id_byte: 8'h50, ready_mode: 1, abort_idx: -1, exp_id_err: 1'b0, name: "rest_clear"};
    vecs[5] = '{dir: 1'b1, id_byte: 8'h50, ready_mode: 1, abort_idx: 4,  exp_id_err: 1'b0, name: "rest_abort"};

    #1;
    checkReset("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i]);
    end

    // Reset in the middle of a save, then a full save from idx 0.
    preload();
    dir   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    sav_ready = 1'b1;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (busy && sst_addr == 8'd6) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checkOutput("mid_save_reach_idx6", 32'(timed_out), 32'd0);
    #2 rst_n = 1'b0;
    #1 checkReset("mid_save_rst");
    @(negedge clk);
    rst_n     = 1'b1;
    sav_ready = 1'b0;
    applyStimulus(vecs[0]);
    checkVector(vecs[0]);

    // Reset during a register write window: strobe drops, write not resumed.
    preload();
    dir   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    rs_valid = 1'b1;
    rs_data  = 8'hAA;
    @(negedge clk);
    rs_valid = 1'b0;
    checkOutput("mid_write_we_on", 32'(sst_we_reg), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkReset("mid_write_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      m2_fall = 1'b1;
      @(negedge clk);
      m2_fall = 1'b0;
      @(negedge clk);
    end
    checkOutput("mid_write_no_resume_we", 32'(sst_we_reg), 32'd0);
    checkOutput("mid_write_reg0_kept", 32'(map_regs[0]), 32'd0);
    checkOutput("mid_write_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
